// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator: G1/G2 Gold-code LFSRs stepped by half-chip strobes, with
// early/prompt/late taps, full-chip and code-epoch pulses, and an hc_enable swallowing
// slew mode.
// Optional feature: define CA_CODE_PHASE_EN to add tic_enable and the code_phase latch.
module ca_code_gen (
   input  logic        clk,
   input  logic        rstn,
   input  logic        hc_enable,
   input  logic [9:0]  prn_key,
   input  logic        prn_key_enable,
   input  logic [10:0] slew,
   input  logic        slew_enable,
   output logic        early,
   output logic        prompt,
   output logic        late,
   output logic        fc_enable,
   output logic        dump_enable,
   output logic        slewing
`ifdef CA_CODE_PHASE_EN
   ,
   input  logic        tic_enable,
   output logic [10:0] code_phase
`endif
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] SLEW = 1'b1;

   logic [0:0]  state;
   logic [9:0]  g1;
   logic [9:0]  g2;
   logic [9:0]  prn_key_reg;
   logic [9:0]  chip_count;
   logic        hc_phase;
   logic [10:0] slew_count;

   logic chip;
   logic g1_fb;
   logic g2_fb;
   logic accept;
   logic full_chip;
   logic last_chip;

   assign chip      = g1[9] ^ g2[9];
   assign g1_fb     = g1[2] ^ g1[9];
   assign g2_fb     = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
   // A key load restarts the code, so a coincident strobe is dropped.
   assign accept    = hc_enable && (state == RUN) && !prn_key_enable;
   assign full_chip = accept && hc_phase;
   assign last_chip = (chip_count == 10'd1022);
   assign slewing   = (state == SLEW);

   // Code state, tap pipeline, chip/epoch pulses and slew FSM.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= RUN;
         g1          <= 10'h3FF;
         g2          <= 10'h3FF;
         prn_key_reg <= 10'h3FF;
         chip_count  <= 10'd0;
         hc_phase    <= 1'b0;
         slew_count  <= 11'd0;
         early       <= 1'b0;
         prompt      <= 1'b0;
         late        <= 1'b0;
         fc_enable   <= 1'b0;
         dump_enable <= 1'b0;
      end else if (prn_key_enable) begin
         g1          <= 10'h3FF;
         g2          <= prn_key;
         prn_key_reg <= prn_key;
         chip_count  <= 10'd0;
         hc_phase    <= 1'b0;
         early       <= 1'b0;
         prompt      <= 1'b0;
         late        <= 1'b0;
         fc_enable   <= 1'b0;
         dump_enable <= 1'b0;
         slew_count  <= slew;
         state       <= (slew != 11'd0) ? SLEW : RUN;
      end else begin
         fc_enable   <= full_chip;
         dump_enable <= full_chip && last_chip;
         if (accept) begin
            hc_phase             <= ~hc_phase;
            {late, prompt, early} <= {prompt, early, chip};
            if (hc_phase) begin
               if (last_chip) begin
                  // Epoch boundary: reload rather than shift so the period is exactly 1023.
                  chip_count <= 10'd0;
                  g1         <= 10'h3FF;
                  g2         <= prn_key_reg;
               end else begin
                  chip_count <= chip_count + 10'd1;
                  g1         <= {g1[8:0], g1_fb};
                  g2         <= {g2[8:0], g2_fb};
               end
            end
         end
         if (slew_enable) begin
            slew_count <= slew;
            state      <= (slew != 11'd0) ? SLEW : RUN;
         end else if ((state == SLEW) && hc_enable) begin
            slew_count <= slew_count - 11'd1;
            if (slew_count <= 11'd1) begin
               state <= RUN;
            end
         end
      end
   end

`ifdef CA_CODE_PHASE_EN
   // Snapshot of the current half-chip position; registers hold pre-update values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         code_phase <= 11'd0;
      end else if (tic_enable) begin
         code_phase <= {chip_count, hc_phase};
      end
   end
`endif

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: directed scenarios against a stage-numbered
// G1/G2 reference of the C/A code. Define CA_CODE_PHASE_EN to include the code_phase test.
module tb_ca_code_gen;

   logic        clk;
   logic        rstn;
   logic        hc_enable;
   logic [9:0]  prn_key;
   logic        prn_key_enable;
   logic [10:0] slew;
   logic        slew_enable;
   logic        early;
   logic        prompt;
   logic        late;
   logic        fc_enable;
   logic        dump_enable;
   logic        slewing;
`ifdef CA_CODE_PHASE_EN
   logic        tic_enable;
   logic [10:0] code_phase;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference chip sequence for the currently loaded key, chip 0 first.
   logic seq [0:1022];

   ca_code_gen dut (
      .clk            (clk),
      .rstn           (rstn),
      .hc_enable      (hc_enable),
      .prn_key        (prn_key),
      .prn_key_enable (prn_key_enable),
      .slew           (slew),
      .slew_enable    (slew_enable),
      .early          (early),
      .prompt         (prompt),
      .late           (late),
      .fc_enable      (fc_enable),
      .dump_enable    (dump_enable),
      .slewing        (slewing)
`ifdef CA_CODE_PHASE_EN
      ,
      .tic_enable     (tic_enable),
      .code_phase     (code_phase)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stages numbered 1..10, output from stage 10, feedback into stage 1.
   // Key bit i is the initial content of G2 stage i+1; G1 starts all ones.
   task automatic build_seq(input logic [9:0] key, output int ones);
      logic s1 [1:10];
      logic s2 [1:10];
      logic f1;
      logic f2;
      for (int i = 1; i <= 10; i++) begin
         s1[i] = 1'b1;
         s2[i] = key[i-1];
      end
      ones = 0;
      for (int n = 0; n < 1023; n++) begin
         seq[n] = s1[10] ^ s2[10];
         if (seq[n]) ones++;
         f1 = s1[3] ^ s1[10];
         f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
         for (int i = 10; i > 1; i--) begin
            s1[i] = s1[i-1];
            s2[i] = s2[i-1];
         end
         s1[1] = f1;
         s2[1] = f2;
      end
   endtask

   // Expected tap value after accepted strobe k (1-based); lag 0/1/2 = early/prompt/late.
   function automatic logic chip_at(input int k, input int lag);
      int j;
      j = k - lag;
      if (j < 1) return 1'b0;
      return seq[((j - 1) / 2) % 1023];
   endfunction

   task automatic load_key(input logic [9:0] key, input logic [10:0] s);
      prn_key        = key;
      slew           = s;
      prn_key_enable = 1'b1;
      @(negedge clk);
      prn_key_enable = 1'b0;
   endtask

   // One hc_enable pulse; outputs sampled one and two clocks later. gap >= 2.
   task automatic hc_step(input int gap, output logic e, output logic p, output logic l,
                          output logic fc, output logic dmp, output logic fc2,
                          output logic sl);
      hc_enable = 1'b1;
      @(negedge clk);
      hc_enable = 1'b0;
      e   = early;
      p   = prompt;
      l   = late;
      fc  = fc_enable;
      dmp = dump_enable;
      sl  = slewing;
      @(negedge clk);
      fc2 = fc_enable | dump_enable;
      repeat (gap - 2) @(negedge clk);
   endtask

   // Issue n accepted strobes numbered k0+1..k0+n and compare every tap and pulse.
   task automatic run_check(input int k0, input int n, input int gap, output int errs,
                            output int first_bad, output int ones, output int dumps,
                            output int last_dump);
      logic e, p, l, fc, dmp, fc2, sl;
      int   k;
      errs = 0; first_bad = -1; ones = 0; dumps = 0; last_dump = -1;
      for (int i = 1; i <= n; i++) begin
         k = k0 + i;
         hc_step(gap, e, p, l, fc, dmp, fc2, sl);
         if (dmp) begin
            dumps++;
            last_dump = k;
         end
         if (p && (k % 2 == 0)) ones++;
         if (e !== chip_at(k, 0) || p !== chip_at(k, 1) || l !== chip_at(k, 2) ||
             fc !== ((k % 2) == 0) || dmp !== ((k % 2046) == 0) || fc2 !== 1'b0 ||
             sl !== 1'b0) begin
            errs++;
            if (first_bad < 0) first_bad = k;
         end
      end
   endtask

   task automatic test_reset();
      int errs, bad, ones, dumps, ld, mones;
      rstn = 1'b0;
      prn_key = 10'h155; slew = 11'd9; prn_key_enable = 1'b1; slew_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hc_enable = i[0];
         @(negedge clk);
      end
      hc_enable = 1'b0; prn_key_enable = 1'b0; slew_enable = 1'b0;
      n_checks++;
      if ({early, prompt, late, fc_enable, dump_enable, slewing} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 000000",
                  {early, prompt, late, fc_enable, dump_enable, slewing});
      end
      n_checks++;
      if ({dut.g1, dut.g2, dut.prn_key_reg} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin
         n_fail++;
         $display("FAIL reset_lfsr: g1 %h g2 %h key %h required 3ff 3ff 3ff",
                  dut.g1, dut.g2, dut.prn_key_reg);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({fc_enable, dump_enable} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_first_clk: fc/dump %b required 00", {fc_enable, dump_enable});
      end
      // Reset key is 3FF; the code must run from that without any key load.
      build_seq(10'h3FF, mones);
      run_check(0, 60, 2, errs, bad, ones, dumps, ld);
      n_checks++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL reset_key_code: %0d bad strobes (first %0d) required 0", errs, bad);
      end
   endtask

   task automatic test_period();
      int errs, bad, ones, dumps, ld, mones;
      build_seq(10'h3EC, mones);
      load_key(10'h3EC, 11'd0);
      n_checks++;
      if ({early, prompt, late, fc_enable, dump_enable, slewing} !== 6'b0) begin
         n_fail++;
         $display("FAIL load_clears: got %b required 000000",
                  {early, prompt, late, fc_enable, dump_enable, slewing});
      end
      run_check(0, 2046, 20, errs, bad, ones, dumps, ld);
      n_checks++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL period_seq: %0d bad strobes (first %0d) required 0", errs, bad);
      end
      n_checks++;
      if (dumps !== 1 || ld !== 2046) begin
         n_fail++;
         $display("FAIL period_dump: %0d dumps last at %0d required 1 at 2046", dumps, ld);
      end
      n_checks++;
      if (ones !== mones) begin
         n_fail++;
         $display("FAIL period_ones: prompt ones %0d required %0d", ones, mones);
      end
   endtask

   task automatic test_prn_table();
      logic [9:0] keys [0:1];
      int errs, bad, ones, dumps, ld, mones;
      keys[0] = 10'h3D8;
      keys[1] = 10'h3B0;
      for (int t = 0; t < 2; t++) begin
         build_seq(keys[t], mones);
         load_key(keys[t], 11'd0);
         run_check(0, 2047, 2, errs, bad, ones, dumps, ld);
         n_checks++;
         if (errs !== 0 || ones !== mones || dumps !== 1) begin
            n_fail++;
            $display("FAIL prn_%h: errs %0d (first %0d) ones %0d dumps %0d required 0 %0d 1",
                     keys[t], errs, bad, ones, dumps, mones);
         end
      end
   endtask

   task automatic test_slew();
      logic e, p, l, fc, dmp, fc2, sl;
      int errs, bad, ones, dumps, ld, mones;
      build_seq(10'h3EC, mones);
      load_key(10'h3EC, 11'd0);
      run_check(0, 100, 2, errs, bad, ones, dumps, ld);
      slew = 11'd3; slew_enable = 1'b1;
      @(negedge clk);
      slew_enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (slewing !== 1'b1 || dut.slew_count !== 11'd3) begin
         n_fail++;
         $display("FAIL slew_enter: slewing %b count %0d required 1 3", slewing, dut.slew_count);
      end
      errs = 0;
      for (int i = 1; i <= 3; i++) begin
         hc_step(2, e, p, l, fc, dmp, fc2, sl);
         if (sl !== (i < 3) || e !== chip_at(100, 0) || p !== chip_at(100, 1) ||
             l !== chip_at(100, 2) || fc !== 1'b0 || dmp !== 1'b0 || fc2 !== 1'b0)
            errs++;
      end
      n_checks++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL slew_frozen: %0d bad swallowed strobes required 0", errs);
      end
      run_check(100, 1946, 2, errs, bad, ones, dumps, ld);
      n_checks++;
      if (errs !== 0 || dumps !== 1 || ld !== 2046) begin
         n_fail++;
         $display("FAIL slew_resume: errs %0d (first %0d) dumps %0d at %0d required 0 1 2046",
                  errs, bad, dumps, ld);
      end
   endtask

   task automatic test_collision();
      int errs, bad, ones, dumps, ld, mones;
      build_seq(10'h3D8, mones);
      load_key(10'h3D8, 11'd0);
      run_check(0, 3, 2, errs, bad, ones, dumps, ld);
      prn_key = 10'h3B0; slew = 11'd0; prn_key_enable = 1'b1; hc_enable = 1'b1;
      @(negedge clk);
      prn_key_enable = 1'b0; hc_enable = 1'b0;
      n_checks++;
      if ({fc_enable, early, prompt, late} !== 4'b0 || dut.chip_count !== 10'd0 ||
          dut.hc_phase !== 1'b0 || dut.g2 !== 10'h3B0) begin
         n_fail++;
         $display("FAIL collision: fc/e/p/l %b chip %0d phase %b g2 %h required 0000 0 0 3b0",
                  {fc_enable, early, prompt, late}, dut.chip_count, dut.hc_phase, dut.g2);
      end
      @(negedge clk);
      build_seq(10'h3B0, mones);
      run_check(0, 4, 2, errs, bad, ones, dumps, ld);
      n_checks++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL collision_restart: %0d bad strobes (first %0d) required 0", errs, bad);
      end
   endtask

   task automatic test_reset_mid_slew();
      logic e, p, l, fc, dmp, fc2, sl;
      load_key(10'h3D8, 11'd100);
      hc_step(2, e, p, l, fc, dmp, fc2, sl);
      hc_step(2, e, p, l, fc, dmp, fc2, sl);
      slew = 11'd50; slew_enable = 1'b1;
      @(negedge clk);
      slew_enable = 1'b0;
      n_checks++;
      if (dut.slew_count !== 11'd50 || slewing !== 1'b1) begin
         n_fail++;
         $display("FAIL slew_overwrite: count %0d slewing %b required 50 1",
                  dut.slew_count, slewing);
      end
      rstn = 1'b0; hc_enable = 1'b1; slew_enable = 1'b1;
      @(negedge clk);
      rstn = 1'b1; hc_enable = 1'b0; slew_enable = 1'b0;
      n_checks++;
      if ({early, prompt, late, fc_enable, dump_enable, slewing} !== 6'b0 ||
          dut.g1 !== 10'h3FF || dut.g2 !== 10'h3FF || dut.slew_count !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid_slew: outs %b g1 %h g2 %h count %0d required 000000 3ff 3ff 0",
                  {early, prompt, late, fc_enable, dump_enable, slewing}, dut.g1, dut.g2,
                  dut.slew_count);
      end
   endtask

`ifdef CA_CODE_PHASE_EN
   task automatic test_code_phase();
      int errs, bad, ones, dumps, ld, mones;
      build_seq(10'h3EC, mones);
      load_key(10'h3EC, 11'd0);
      run_check(0, 7, 2, errs, bad, ones, dumps, ld);
      tic_enable = 1'b1;
      @(negedge clk);
      tic_enable = 1'b0;
      n_checks++;
      if (code_phase !== 11'h007) begin
         n_fail++;
         $display("FAIL code_phase_7: got %h required 007", code_phase);
      end
      // Tic together with accepted strobe 8 sees the pre-update position.
      tic_enable = 1'b1; hc_enable = 1'b1;
      @(negedge clk);
      tic_enable = 1'b0; hc_enable = 1'b0;
      n_checks++;
      if (code_phase !== 11'h007) begin
         n_fail++;
         $display("FAIL code_phase_same_clk: got %h required 007", code_phase);
      end
      @(negedge clk);
      run_check(8, 2037, 2, errs, bad, ones, dumps, ld);
      tic_enable = 1'b1;
      @(negedge clk);
      tic_enable = 1'b0;
      n_checks++;
      if (code_phase !== 11'h7FD) begin
         n_fail++;
         $display("FAIL code_phase_end: got %h required 7fd", code_phase);
      end
   endtask
`endif

   initial begin
      rstn = 1'b0; hc_enable = 1'b0; prn_key = 10'h0; prn_key_enable = 1'b0;
      slew = 11'd0; slew_enable = 1'b0;
`ifdef CA_CODE_PHASE_EN
      tic_enable = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_period();
      test_prn_table();
      test_slew();
      test_collision();
      test_reset_mid_slew();
`ifdef CA_CODE_PHASE_EN
      test_code_phase();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ca_code_gen.md
CA_CODE_GEN -- requirements
Module: ca_code_gen

Interface
REQ-001 SHALL have port clk, input, 1, system clock (40 MHz); all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-003 SHALL have port hc_enable, input, 1, half-chip strobe from the code NCO; one-clk pulse.
REQ-004 SHALL have port prn_key, input, 10, G2 initial state selecting the satellite PRN.
REQ-005 SHALL have port prn_key_enable, input, 1, one-clk pulse; loads prn_key and restarts the code.
REQ-006 SHALL have port slew, input, 11, number of hc_enable pulses to swallow (0..2045).
REQ-007 SHALL have port slew_enable, input, 1, one-clk pulse; loads slew.
REQ-008 SHALL have port tic_enable, input, 1, measurement tic strobe; used only with CA_CODE_PHASE_EN.
REQ-009 SHALL have port early, output, 1, early code chip.
REQ-010 SHALL have port prompt, output, 1, prompt code chip, half a chip after early.
REQ-011 SHALL have port late, output, 1, late code chip, half a chip after prompt.
REQ-012 SHALL have port fc_enable, output, 1, registered full-chip pulse.
REQ-013 SHALL have port dump_enable, output, 1, registered code-epoch pulse.
REQ-014 SHALL have port slewing, output, 1, high while in SLEW.
REQ-015 SHALL have port code_phase, output, 11, {chip_count, hc_phase} latched on tic_enable; present only with CA_CODE_PHASE_EN.

Function
REQ-016 SHALL hold g1[9:0] and g2[9:0] LFSRs: g1 feedback g1[2]^g1[9]; g2 feedback g2[1]^g2[2]^g2[5]^g2[7]^g2[8]^g2[9]; shift {reg[8:0],fb}.
REQ-017 SHALL define chip = g1[9]^g2[9], taken from the pre-shift state.
REQ-018 SHALL implement a two-state FSM RUN/SLEW; an hc_enable is "accepted" only in RUN.
REQ-019 On each accepted hc_enable, SHALL toggle hc_phase and shift {late,prompt,early} <= {prompt,early,chip}.
REQ-020 On an accepted hc_enable with hc_phase==1, SHALL shift g1/g2 and increment chip_count (0..1022), with fc_enable high for exactly the next clk.
REQ-021 When chip_count==1022 advances, SHALL wrap chip_count to 0, force g1=10'h3FF and g2=prn_key_reg, and assert dump_enable coincident with that fc_enable.
REQ-022 On prn_key_enable, SHALL set g1=10'h3FF, g2=prn_key, prn_key_reg=prn_key, chip_count=0, hc_phase=0 and early/prompt/late=0, and load slew_count=slew.
REQ-023 prn_key_enable SHALL take priority over a same-cycle hc_enable (the strobe is dropped) and over slew_enable.
REQ-024 On slew_enable (or prn_key_enable) with slew!=0, SHALL enter SLEW; with slew==0, SHALL remain in/return to RUN.
REQ-025 In SLEW, each hc_enable SHALL decrement slew_count without advancing the code; the decrement to 0 SHALL return the FSM to RUN the following cycle.
REQ-026 slew_enable received during SLEW SHALL overwrite slew_count.
REQ-027 fc_enable and dump_enable SHALL never assert in SLEW or within the first clk after reset.
REQ-028 Code period SHALL be exactly 1023 chips = 2046 accepted hc_enable.

Reset
REQ-029 With rstn low at a clk edge, SHALL set g1=g2=prn_key_reg=10'h3FF, chip_count=0, hc_phase=0, slew_count=0, FSM=RUN, and drive early/prompt/late/fc_enable/dump_enable/slewing/code_phase to 0.
REQ-030 Reset SHALL override every other input, including mid-slew and mid-chip.

Configuration
REQ-031 With macro CA_CODE_PHASE_EN defined, SHALL latch code_phase <= {chip_count,hc_phase} on tic_enable (reset 0); a same-cycle accepted hc_enable SHALL latch the pre-update value.
REQ-032 Without CA_CODE_PHASE_EN, the code_phase port, its register and the use of tic_enable SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 Reset, then prn_key_enable with slew=0 and hc_enable every 20 clk -> dump_enable every 2046 hc_enable (40920 clk); prompt holds 512 ones/511 zeros per period.
REQ-034 Each PRN key in the team PRN table, 1023 chips -> prompt sequence equal to the golden C/A model; early leads prompt, and prompt leads late, by exactly one hc_enable.
REQ-035 slew_enable with slew=3 mid-code -> slewing high for 3 hc_enable, code frozen, then dump_enable 3 hc_enable later than unslewed.
REQ-036 prn_key_enable and hc_enable in the same clk -> hc_enable ignored, chip_count=0, hc_phase=0, no fc_enable.
REQ-037 rstn low during SLEW with slew_count=100 -> next clk slewing=0, all outputs 0, g1=g2=10'h3FF.
REQ-038 (CA_CODE_PHASE_EN) tic_enable after 7 accepted hc_enable from start -> code_phase=11'h007; tic_enable at chip 1022, hc_phase 1 -> 11'h7FD.
